sfx_arbiter: RTL and testbench
==============================

Name: sfx_arbiter

Overview:
- Shares the single Audio tone generator between game sound-effect requesters: player death, level complete, continue/start, and player movement.
- Captures request edges and grants by fixed priority. Higher priority preempts.
- Holds each tone for a per-requester duration in milliseconds, then inserts a silent gap.
- Drives the Audio block's 3-bit tone select and enable, replacing the direct keyboard-to-decoder path.

Parameters:
- NUM_REQ, 4: number of requesters. Index 0 has the highest priority.
- TICK_DIV, 100000: clk cycles per 1 ms tick (100 MHz clk).
- GAP_MS, 20: silent gap in ms between consecutive tones.
- DUR_W, 8: width of each duration field in ms.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mute  in  1  high = audio disabled (the top-level en switch, inverted)
- req  in  NUM_REQ  request levels, synchronous to clk. Rising edge = one request.
- tone  in  3*NUM_REQ  per-requester tone code; requester i uses bits [3i+2:3i]
- dur_ms  in  DUR_W*NUM_REQ  per-requester duration in ms; requester i uses bits [DUR_W*i+DUR_W-1:DUR_W*i]
- sel  out  3  tone select to Audio
- en_o  out  1  audio enable to Audio
- gnt  out  NUM_REQ  one-hot owner of the tone generator; all zero when none
- busy  out  1  high in PLAY or GAP
- drop_cnt  out  8  count of preempted tones, saturating at 255

Behaviour:
- All outputs are registered. While rst=0: state=IDLE, sel=0, en_o=0, gnt=0, busy=0, drop_cnt=0, pending=0, req_q=0, all counters=0.
- Edge capture:
  - req_q <= req.
  - pending[i] is set when req[i] & ~req_q[i].
  - pending[i] is cleared in the cycle requester i is granted. If a set and a clear of the same bit coincide, the set wins (bit stays 1).
- Winner = lowest-index set bit of pending.
- Tick:
  - A free-running divider asserts tick for one cycle every TICK_DIV cycles.
  - The divider is cleared to 0 on every entry to PLAY or GAP, so the first tick arrives exactly TICK_DIV cycles later.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - If mute=0 and pending is non-zero, go to PLAY.
  - Latch cur=winner, sel=tone[cur], ms_left=max(dur_ms[cur],1).
  - Set gnt=onehot(cur), en_o=1, busy=1.
  - While mute=1, pending is retained and nothing is granted.
- PLAY:
  - On tick, ms_left decrements.
  - When ms_left==1 and tick: go to GAP with en_o=0, gnt=0, sel=0, gap_left=GAP_MS.
- Preemption: in PLAY, if the winner index < cur, switch to the new winner the next cycle.
  - The divider is cleared, drop_cnt increments, and the old tone is not re-queued.
  - Lower or equal priority requests wait.
- GAP:
  - On tick, gap_left decrements. At 1 & tick, go to IDLE; busy=0 unless IDLE immediately grants.
  - GAP_MS=0 means GAP lasts exactly one cycle.
  - Preemption does not apply in GAP.
- mute rising while in PLAY or GAP: go to IDLE next cycle. en_o=0, gnt=0, sel=0. pending is kept.
- Re-request: a new edge on the currently playing index during PLAY sets pending and replays that tone after the gap.
- Latency: req edge sampled at cycle N → pending visible at N+1 → en_o=1, gnt, sel valid at N+2 (state IDLE, mute=0).
- Tone duration: exactly ms_left*TICK_DIV cycles from the en_o rise (±0 cycles), absent preemption.

Decomposition:
- Shared package (game_pkg):
  - state encoding S_IDLE/S_PLAY/S_GAP.
  - requester index constants REQ_DEAD=0, REQ_LVL=1, REQ_CONT=2, REQ_MOVE=3.
  - SEL_SILENT=3'd0.
  - default tone/duration constants.
- Sub-module sfx_tick_gen: the TICK_DIV divider with synchronous clear input and tick output. Everything else stays in sfx_arbiter.

Test Plan (TICK_DIV=10, GAP_MS=2, dur_ms={5,4,3,2} for requesters 3..0):
- Reset, then pulse req[2] at cycle 0 → at cycle 2: gnt=0100, sel=tone[2], en_o=1. en_o falls at cycle 42 (4 ms). busy falls at cycle 62.
- req[3] and req[1] rise in the same cycle → req[1] plays first for 3 ms. After the 2 ms gap, req[3] plays 5 ms. drop_cnt=0.
- req[3] playing, req[0] rises at ms 2 → two cycles later gnt=0001, sel=tone[0]. Plays 2 ms full. drop_cnt=1. Tone 3 does not resume.
- req[0] playing, req[2] rises → no preemption. req[2] plays after GAP. drop_cnt unchanged.
- mute=1 with req[1] pulsed → en_o stays 0 and pending[1] is held. Release mute → grant within 2 cycles.
- Assert rst (low) mid-PLAY → en_o, gnt, sel, busy, drop_cnt go to 0 asynchronously. After release, no grant without a new req edge.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared sound-effect arbiter types (state encoding, requester indices, silent select, default tones/durations)
package game_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
  localparam int REQ_DEAD = 0;
  localparam int REQ_LVL = 1;
  localparam int REQ_CONT = 2;
  localparam int REQ_MOVE = 3;
  localparam logic [2:0] SEL_SILENT = 3'd0;
  localparam logic [11:0] DEF_TONE = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [31:0] DEF_DUR_MS = {8'd5, 8'd4, 8'd3, 8'd2};
endpackage

// File: rtl/sfx_tick_gen.sv
// sfx_tick_gen: 1 ms tick divider; clk, rst (async active-low), clr (sync restart), tick (one cycle every TICK_DIV cycles)
module sfx_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/sfx_arbiter.sv
// sfx_arbiter: priority tone arbiter; in clk/rst(async low)/mute/req/tone/dur_ms, out sel/en_o/gnt/busy/drop_cnt
module sfx_arbiter
  import game_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS = 20,
  parameter int DUR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mute,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [3*NUM_REQ-1:0]     tone,
  input  logic [DUR_W*NUM_REQ-1:0] dur_ms,
  output logic [2:0]               sel,
  output logic                     en_o,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [7:0]               drop_cnt
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int GW = GAP_MS > 0 ? $clog2(GAP_MS + 1) : 1;
  state_t state;
  logic [NUM_REQ-1:0] req_q, pending, win_oh;
  logic [IW-1:0] cur, win;
  logic [DUR_W-1:0] ms_left, win_dur;
  logic [GW-1:0] gap_left;
  logic tick, clr, grant, gap_end;
  sfx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(clr), .tick(tick));
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) win = pending[i] ? IW'(i) : win;
    win_oh = NUM_REQ'(1) << win;
    win_dur = dur_ms[DUR_W*win +: DUR_W];
    gap_end = state == S_GAP && (gap_left == '0 || (tick && gap_left == GW'(1)));
    grant = !mute && |pending && (state == S_IDLE || gap_end || (state == S_PLAY && win < cur));
    clr = grant || (state == S_PLAY && tick && ms_left == DUR_W'(1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      req_q <= '0;
      pending <= '0;
      cur <= '0;
      ms_left <= '0;
      gap_left <= '0;
      sel <= SEL_SILENT;
      en_o <= 1'b0;
      gnt <= '0;
      busy <= 1'b0;
      drop_cnt <= '0;
    end else begin
      req_q <= req;
      pending <= (pending & ~(grant ? win_oh : '0)) | (req & ~req_q);
      if (grant) begin
        state <= S_PLAY;
        cur <= win;
        sel <= tone[3*win +: 3];
        ms_left <= win_dur == '0 ? DUR_W'(1) : win_dur;
        gnt <= win_oh;
        en_o <= 1'b1;
        busy <= 1'b1;
        drop_cnt <= drop_cnt + (state == S_PLAY && drop_cnt != 8'hff ? 8'd1 : 8'd0);
      end else if (state != S_IDLE && mute) begin
        state <= S_IDLE;
        sel <= SEL_SILENT;
        en_o <= 1'b0;
        gnt <= '0;
        busy <= 1'b0;
      end else if (state == S_PLAY && tick) begin
        if (ms_left == DUR_W'(1)) begin
          state <= S_GAP;
          sel <= SEL_SILENT;
          en_o <= 1'b0;
          gnt <= '0;
          gap_left <= GW'(GAP_MS);
        end else ms_left <= ms_left - DUR_W'(1);
      end else if (gap_end) begin
        state <= S_IDLE;
        busy <= 1'b0;
      end else if (state == S_GAP && tick) gap_left <= gap_left - GW'(1);
    end
  end
endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: scenario tasks with a grant scoreboard for sfx_arbiter (TICK_DIV=10, GAP_MS=2)
module tb_sfx_arbiter;
  import game_pkg::*;
  logic clk = 1'b0, rst = 1'b0, mute = 1'b0;
  logic [3:0] req = '0;
  logic [11:0] tone = DEF_TONE;
  logic [31:0] dur_ms = DEF_DUR_MS;
  logic [2:0] sel;
  logic en_o, busy;
  logic [3:0] gnt;
  logic [7:0] drop_cnt;
  logic [3:0] prev_gnt = '0;
  logic [6:0] exp_q[$], obs_q[$];
  logic [6:0] e, o;
  int n_cmp = 0, n_bad = 0, exp_drop = 0;
  sfx_arbiter #(.NUM_REQ(4), .TICK_DIV(10), .GAP_MS(2), .DUR_W(8)) dut (
    .clk(clk), .rst(rst), .mute(mute), .req(req), .tone(tone), .dur_ms(dur_ms),
    .sel(sel), .en_o(en_o), .gnt(gnt), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (gnt != '0 && gnt != prev_gnt) obs_q.push_back({gnt, sel});
    prev_gnt = gnt;
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    step(3);
    n_cmp++;
    if ({gnt, sel, en_o, busy, drop_cnt} !== 17'd0) begin n_bad++; $display("FAIL reset_state: got %b required 0", {gnt, sel, en_o, busy, drop_cnt}); end
    rst = 1'b1;
    step(5);
    n_cmp++;
    if ({gnt, en_o, busy} !== 6'd0) begin n_bad++; $display("FAIL reset_idle: got %b required 0", {gnt, en_o, busy}); end
  endtask
  task automatic test_single;
    req[REQ_CONT] = 1'b1;
    exp_q.push_back({4'b0100, tone[3*REQ_CONT +: 3]});
    step(1);
    req = '0;
    n_cmp++;
    if ({gnt, en_o} !== 5'd0) begin n_bad++; $display("FAIL single_latency1: got %b required 0", {gnt, en_o}); end
    step(1);
    n_cmp++;
    if ({gnt, sel, en_o, busy} !== {4'b0100, tone[3*REQ_CONT +: 3], 2'b11}) begin n_bad++; $display("FAIL single_grant: got %b required %b", {gnt, sel, en_o, busy}, {4'b0100, tone[3*REQ_CONT +: 3], 2'b11}); end
    step(39);
    n_cmp++;
    if (en_o !== 1'b1) begin n_bad++; $display("FAIL single_en41: got %b required 1", en_o); end
    step(1);
    n_cmp++;
    if ({gnt, sel, en_o, busy} !== 9'b0000_000_01) begin n_bad++; $display("FAIL single_gap42: got %b required 000000001", {gnt, sel, en_o, busy}); end
    step(19);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy61: got %b required 1", busy); end
    step(1);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy62: got %b required 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL single_sb: got none required %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL single_sb: got %b required %b", o, e); end end
    end
  endtask
  task automatic test_priority;
    req[REQ_MOVE] = 1'b1;
    req[REQ_LVL] = 1'b1;
    exp_q.push_back({4'b0010, tone[3*REQ_LVL +: 3]});
    exp_q.push_back({4'b1000, tone[3*REQ_MOVE +: 3]});
    step(1);
    req = '0;
    step(1);
    n_cmp++;
    if ({gnt, sel, en_o, busy} !== {4'b0010, tone[3*REQ_LVL +: 3], 2'b11}) begin n_bad++; $display("FAIL prio_first: got %b required %b", {gnt, sel, en_o, busy}, {4'b0010, tone[3*REQ_LVL +: 3], 2'b11}); end
    step(29);
    n_cmp++;
    if (en_o !== 1'b1) begin n_bad++; $display("FAIL prio_en31: got %b required 1", en_o); end
    step(1);
    n_cmp++;
    if ({gnt, en_o, busy} !== 6'b0000_01) begin n_bad++; $display("FAIL prio_gap32: got %b required 000001", {gnt, en_o, busy}); end
    step(20);
    n_cmp++;
    if ({gnt, sel, en_o, busy} !== {4'b1000, tone[3*REQ_MOVE +: 3], 2'b11}) begin n_bad++; $display("FAIL prio_second: got %b required %b", {gnt, sel, en_o, busy}, {4'b1000, tone[3*REQ_MOVE +: 3], 2'b11}); end
    step(49);
    n_cmp++;
    if (en_o !== 1'b1) begin n_bad++; $display("FAIL prio_en101: got %b required 1", en_o); end
    step(1);
    n_cmp++;
    if ({en_o, busy} !== 2'b01) begin n_bad++; $display("FAIL prio_gap102: got %b required 01", {en_o, busy}); end
    step(20);
    n_cmp++;
    if ({busy, drop_cnt} !== {1'b0, 8'(exp_drop)}) begin n_bad++; $display("FAIL prio_end: got %b required %b", {busy, drop_cnt}, {1'b0, 8'(exp_drop)}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL prio_sb: got none required %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL prio_sb: got %b required %b", o, e); end end
    end
  endtask
  task automatic test_preempt;
    req[REQ_MOVE] = 1'b1;
    exp_q.push_back({4'b1000, tone[3*REQ_MOVE +: 3]});
    step(1);
    req = '0;
    step(1);
    n_cmp++;
    if ({gnt, sel, en_o} !== {4'b1000, tone[3*REQ_MOVE +: 3], 1'b1}) begin n_bad++; $display("FAIL pre_first: got %b required %b", {gnt, sel, en_o}, {4'b1000, tone[3*REQ_MOVE +: 3], 1'b1}); end
    step(20);
    req[REQ_DEAD] = 1'b1;
    exp_q.push_back({4'b0001, tone[3*REQ_DEAD +: 3]});
    exp_drop++;
    step(1);
    req = '0;
    n_cmp++;
    if (gnt !== 4'b1000) begin n_bad++; $display("FAIL pre_hold23: got %b required 1000", gnt); end
    step(1);
    n_cmp++;
    if ({gnt, sel, en_o, busy, drop_cnt} !== {4'b0001, tone[3*REQ_DEAD +: 3], 2'b11, 8'(exp_drop)}) begin n_bad++; $display("FAIL pre_switch: got %b required %b", {gnt, sel, en_o, busy, drop_cnt}, {4'b0001, tone[3*REQ_DEAD +: 3], 2'b11, 8'(exp_drop)}); end
    step(19);
    n_cmp++;
    if (en_o !== 1'b1) begin n_bad++; $display("FAIL pre_en43: got %b required 1", en_o); end
    step(1);
    n_cmp++;
    if ({gnt, en_o, busy} !== 6'b0000_01) begin n_bad++; $display("FAIL pre_gap44: got %b required 000001", {gnt, en_o, busy}); end
    step(20);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL pre_busy64: got %b required 0", busy); end
    step(16);
    n_cmp++;
    if ({gnt, en_o, busy} !== 6'd0) begin n_bad++; $display("FAIL pre_noresume: got %b required 0", {gnt, en_o, busy}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL pre_sb: got none required %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL pre_sb: got %b required %b", o, e); end end
    end
  endtask
  task automatic test_no_preempt;
    req[REQ_DEAD] = 1'b1;
    exp_q.push_back({4'b0001, tone[3*REQ_DEAD +: 3]});
    step(1);
    req = '0;
    step(1);
    n_cmp++;
    if ({gnt, en_o} !== 5'b0001_1) begin n_bad++; $display("FAIL nopre_first: got %b required 00011", {gnt, en_o}); end
    step(3);
    req[REQ_CONT] = 1'b1;
    exp_q.push_back({4'b0100, tone[3*REQ_CONT +: 3]});
    step(1);
    req = '0;
    step(15);
    n_cmp++;
    if ({gnt, sel, en_o} !== {4'b0001, tone[3*REQ_DEAD +: 3], 1'b1}) begin n_bad++; $display("FAIL nopre_hold21: got %b required %b", {gnt, sel, en_o}, {4'b0001, tone[3*REQ_DEAD +: 3], 1'b1}); end
    step(1);
    n_cmp++;
    if ({gnt, en_o, busy} !== 6'b0000_01) begin n_bad++; $display("FAIL nopre_gap22: got %b required 000001", {gnt, en_o, busy}); end
    step(20);
    n_cmp++;
    if ({gnt, sel, en_o, busy, drop_cnt} !== {4'b0100, tone[3*REQ_CONT +: 3], 2'b11, 8'(exp_drop)}) begin n_bad++; $display("FAIL nopre_second: got %b required %b", {gnt, sel, en_o, busy, drop_cnt}, {4'b0100, tone[3*REQ_CONT +: 3], 2'b11, 8'(exp_drop)}); end
    step(40);
    n_cmp++;
    if ({en_o, busy} !== 2'b01) begin n_bad++; $display("FAIL nopre_gap82: got %b required 01", {en_o, busy}); end
    step(20);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL nopre_busy102: got %b required 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL nopre_sb: got none required %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL nopre_sb: got %b required %b", o, e); end end
    end
  endtask
  task automatic test_mute;
    mute = 1'b1;
    req[REQ_LVL] = 1'b1;
    exp_q.push_back({4'b0010, tone[3*REQ_LVL +: 3]});
    step(1);
    req = '0;
    step(9);
    n_cmp++;
    if ({gnt, sel, en_o, busy} !== 9'd0) begin n_bad++; $display("FAIL mute_hold: got %b required 0", {gnt, sel, en_o, busy}); end
    mute = 1'b0;
    step(1);
    n_cmp++;
    if ({gnt, sel, en_o, busy} !== {4'b0010, tone[3*REQ_LVL +: 3], 2'b11}) begin n_bad++; $display("FAIL mute_release: got %b required %b", {gnt, sel, en_o, busy}, {4'b0010, tone[3*REQ_LVL +: 3], 2'b11}); end
    step(4);
    mute = 1'b1;
    step(1);
    n_cmp++;
    if ({gnt, sel, en_o, busy} !== 9'd0) begin n_bad++; $display("FAIL mute_play: got %b required 0", {gnt, sel, en_o, busy}); end
    mute = 1'b0;
    step(4);
    n_cmp++;
    if ({gnt, en_o, busy} !== 6'd0) begin n_bad++; $display("FAIL mute_norequeue: got %b required 0", {gnt, en_o, busy}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL mute_sb: got none required %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL mute_sb: got %b required %b", o, e); end end
    end
  endtask
  task automatic test_async_reset;
    req[REQ_MOVE] = 1'b1;
    exp_q.push_back({4'b1000, tone[3*REQ_MOVE +: 3]});
    step(1);
    req = '0;
    step(8);
    n_cmp++;
    if ({gnt, en_o, drop_cnt} !== {4'b1000, 1'b1, 8'(exp_drop)}) begin n_bad++; $display("FAIL arst_before: got %b required %b", {gnt, en_o, drop_cnt}, {4'b1000, 1'b1, 8'(exp_drop)}); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, sel, en_o, busy, drop_cnt} !== 17'd0) begin n_bad++; $display("FAIL arst_async: got %b required 0", {gnt, sel, en_o, busy, drop_cnt}); end
    @(posedge clk);
    #1 rst = 1'b1;
    step(20);
    n_cmp++;
    if ({gnt, en_o, busy, drop_cnt} !== 14'd0) begin n_bad++; $display("FAIL arst_nogrant: got %b required 0", {gnt, en_o, busy, drop_cnt}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL arst_sb: got none required %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL arst_sb: got %b required %b", o, e); end end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL extra_grants: got %0d required 0", obs_q.size()); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_priority;
    test_preempt;
    test_no_preempt;
    test_mute;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
